// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-way SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, requester IDs, default widths, RR pointer values.
package sram_arb_pkg;

    localparam int ADDR_W_DEF        = 20;
    localparam int DATA_W_DEF        = 16;
    localparam int VGA_MAX_BURST_DEF = 8;

    // Requester IDs double as bit positions in the one-hot grant vector.
    localparam logic [1:0] RID_VGA  = 2'd0;
    localparam logic [1:0] RID_ACC  = 2'd1;
    localparam logic [1:0] RID_HOST = 2'd2;

    // Round-robin pointer: which of ACC/HOST is preferred on the next tie.
    localparam logic RR_ACC  = 1'b0;
    localparam logic RR_HOST = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_CAP  = 3'd2,
        WR      = 3'd3,
        WR_HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner picker: VGA first, ACC/HOST by round-robin pointer.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides whether the pick is used this cycle.
// Ports: i_*_req request lines, i_rr_ptr RR preference, i_force_rr overrides
//        VGA priority when ACC/HOST pend; o_vld any winner, o_gnt one-hot
//        {HOST,ACC,VGA}, o_id winner ID.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic       i_vga_req,
    input  logic       i_acc_req,
    input  logic       i_host_req,
    input  logic       i_rr_ptr,
    input  logic       i_force_rr,
    output logic       o_vld,
    output logic [2:0] o_gnt,
    output logic [1:0] o_id
);

    logic w_rr_acc;
    logic w_rr_host;
    logic w_vga_wins;

    // ACC wins the RR pair if HOST is idle or the pointer prefers ACC.
    assign w_rr_acc   = i_acc_req && (!i_host_req || (i_rr_ptr == RR_ACC));
    assign w_rr_host  = i_host_req && !w_rr_acc;
    assign w_vga_wins = i_vga_req && !(i_force_rr && (i_acc_req || i_host_req));

    always_comb begin
        o_vld = 1'b0;
        o_gnt = 3'b000;
        o_id  = RID_VGA;
        if (w_vga_wins) begin
            o_vld = 1'b1;
            o_gnt = 3'b001;
            o_id  = RID_VGA;
        end else if (w_rr_acc) begin
            o_vld = 1'b1;
            o_gnt = 3'b010;
            o_id  = RID_ACC;
        end else if (w_rr_host) begin
            o_vld = 1'b1;
            o_gnt = 3'b100;
            o_id  = RID_HOST;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one async 16-bit SRAM between VGA, ACC and HOST; 2-cycle accesses.
// Latency: ack one cycle after grant edge; rvalid two cycles after grant edge.
// Backpressure: req held until ack; losers simply wait, one access per 2 cycles.
// Ports: *_req/addr/we/wdata/be requester side, *_ack accept pulses,
//        rvalid/rid/rdata read return, sram_* pad-ring pins (all registered).
// Option: SRAM_ARB_STARVE_GUARD_EN bounds consecutive VGA grants to
//         VGA_MAX_BURST while ACC/HOST wait; undefined = strict VGA priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int VGA_MAX_BURST = VGA_MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic              acc_req,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              acc_we,
    input  logic              host_we,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [1:0]        acc_be,
    input  logic [1:0]        host_be,
    output logic              vga_ack,
    output logic              acc_ack,
    output logic              host_ack,
    output logic              rvalid,
    output logic [1:0]        rid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dq_out;
    logic              r_dq_oe;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_ub_n;
    logic              r_lb_n;
    logic [2:0]        r_ack;
    logic              r_rvalid;
    logic [1:0]        r_rid;
    logic [1:0]        r_cur_id;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rr_ptr;

    logic              w_arb_state;
    logic              w_grant;
    logic              w_force_rr;
    logic              w_pick_vld;
    logic [2:0]        w_pick_gnt;
    logic [1:0]        w_pick_id;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_we;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_sel_be;

    sram_arb_pick u_pick (
        .i_vga_req  (vga_req),
        .i_acc_req  (acc_req),
        .i_host_req (host_req),
        .i_rr_ptr   (r_rr_ptr),
        .i_force_rr (w_force_rr),
        .o_vld      (w_pick_vld),
        .o_gnt      (w_pick_gnt),
        .o_id       (w_pick_id)
    );

    // The last cycle of each access doubles as the arbitration slot, which
    // is what gives back-to-back accesses every two cycles.
    assign w_arb_state = (r_state == IDLE) || (r_state == RD_CAP) || (r_state == WR_HOLD);
    assign w_grant     = w_arb_state && w_pick_vld;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(VGA_MAX_BURST + 1);

    logic [CNT_W-1:0] r_vga_cnt;
    logic             w_others_pend;

    assign w_others_pend = acc_req || host_req;
    assign w_force_rr    = w_others_pend && (r_vga_cnt >= CNT_W'(VGA_MAX_BURST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vga_cnt <= '0;
        end else if (!w_others_pend) begin
            r_vga_cnt <= '0;
        end else if (w_grant) begin
            r_vga_cnt <= w_pick_gnt[0] ? (r_vga_cnt + 1'b1) : '0;
        end
    end
`else
    logic w_unused_burst;

    assign w_force_rr     = 1'b0;
    assign w_unused_burst = (VGA_MAX_BURST > 0);
`endif

    // Request field mux by winner; VGA is always a full-word read.
    always_comb begin
        w_sel_addr  = vga_addr;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        w_sel_be    = 2'b11;
        if (w_pick_gnt[1]) begin
            w_sel_addr  = acc_addr;
            w_sel_we    = acc_we;
            w_sel_wdata = acc_wdata;
            w_sel_be    = acc_be;
        end else if (w_pick_gnt[2]) begin
            w_sel_addr  = host_addr;
            w_sel_we    = host_we;
            w_sel_wdata = host_wdata;
            w_sel_be    = host_be;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            RD:      w_state_nxt = RD_CAP;
            WR:      w_state_nxt = WR_HOLD;
            default: w_state_nxt = w_pick_vld ? (w_sel_we ? WR : RD) : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_ub_n   <= 1'b1;
            r_lb_n   <= 1'b1;
            r_ack    <= 3'b000;
            r_rvalid <= 1'b0;
            r_rid    <= RID_VGA;
            r_cur_id <= RID_VGA;
            r_rdata  <= '0;
            r_rr_ptr <= RR_ACC;
        end else begin
            r_state  <= w_state_nxt;
            r_ack    <= w_grant ? w_pick_gnt : 3'b000;
            r_rvalid <= (r_state == RD_CAP);

            if (r_state == RD_CAP) begin
                r_rdata <= sram_dq;
                r_rid   <= r_cur_id;
            end

            if (w_grant) begin
                r_addr   <= w_sel_addr;
                r_dq_out <= w_sel_wdata;
                r_cur_id <= w_pick_id;
                if (w_pick_gnt[1]) begin
                    r_rr_ptr <= RR_HOST;
                end else if (w_pick_gnt[2]) begin
                    r_rr_ptr <= RR_ACC;
                end
            end

            // Pins are set for the state being entered so they are registered.
            case (w_state_nxt)
                RD, RD_CAP: begin
                    r_ce_n  <= 1'b0;
                    r_oe_n  <= 1'b0;
                    r_we_n  <= 1'b1;
                    r_ub_n  <= 1'b0;
                    r_lb_n  <= 1'b0;
                    r_dq_oe <= 1'b0;
                end
                WR: begin
                    // be=00 still runs the slot, but never strobes we_n.
                    r_ce_n  <= 1'b0;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= (w_sel_be == 2'b00);
                    r_ub_n  <= ~w_sel_be[1];
                    r_lb_n  <= ~w_sel_be[0];
                    r_dq_oe <= 1'b1;
                end
                WR_HOLD: begin
                    // Keep dq and byte lanes for data hold after we_n rises.
                    r_ce_n  <= 1'b0;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_dq_oe <= 1'b1;
                end
                default: begin
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
            endcase
        end
    end

    assign sram_dq   = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_ub_n = r_ub_n;
    assign sram_lb_n = r_lb_n;
    assign vga_ack   = r_ack[0];
    assign acc_ack   = r_ack[1];
    assign host_ack  = r_ack[2];
    assign rvalid    = r_rvalid;
    assign rid       = r_rid;
    assign rdata     = r_rdata;

endmodule
